// File: rtl/rtr_channel_output_sched_if.sv
// Channel bundle between the VC requesters and the output scheduler.
// The scheduler drives grants, flit control fields and link status.
interface rtr_channel_output_sched_if #(
  parameter int num_vcs = 4
);
  localparam int vc_idx_width =
    (num_vcs > 1) ? $clog2(num_vcs) : 1;

  logic [num_vcs-1:0]      req_ivc;
  logic [num_vcs-1:0]      req_head_ivc;
  logic [num_vcs-1:0]      req_tail_ivc;
  logic [num_vcs-1:0]      credit_ivc;
  logic [num_vcs-1:0]      gnt_ivc;
  logic                    flit_valid_out;
  logic [vc_idx_width-1:0] flit_vc_out;
  logic                    flit_head_out;
  logic                    flit_tail_out;
  logic                    link_active_out;
  logic                    credit_err_out;

  modport master (
    input  req_ivc,
    input  req_head_ivc,
    input  req_tail_ivc,
    input  credit_ivc,
    output gnt_ivc,
    output flit_valid_out,
    output flit_vc_out,
    output flit_head_out,
    output flit_tail_out,
    output link_active_out,
    output credit_err_out
  );

  modport slave (
    output req_ivc,
    output req_head_ivc,
    output req_tail_ivc,
    output credit_ivc,
    input  gnt_ivc,
    input  flit_valid_out,
    input  flit_vc_out,
    input  flit_head_out,
    input  flit_tail_out,
    input  link_active_out,
    input  credit_err_out
  );
endinterface

// File: rtl/rtr_channel_output_sched.sv
// Send-side output channel scheduler: credit-gated round-robin
// over VCs, registered flit control fields and link sleep FSM.
module rtr_channel_output_sched #(
  parameter int num_vcs        = 4,
  parameter int buffer_size    = 8,
  parameter int enable_link_pm = 1,
  parameter int idle_timeout   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  rtr_channel_output_sched_if.master ch
);
  localparam int vc_idx_width =
    (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int cred_width = $clog2(buffer_size + 1);
  localparam int idle_width = $clog2(idle_timeout + 1);

  localparam logic [cred_width-1:0] cred_max =
    cred_width'(buffer_size);
  localparam logic [idle_width-1:0] idle_max =
    idle_width'(idle_timeout);
  localparam logic [vc_idx_width-1:0] last_vc =
    vc_idx_width'(num_vcs - 1);

  typedef enum logic {
    SLEEP  = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam state_t reset_state =
    (enable_link_pm != 0) ? SLEEP : ACTIVE;

  state_t                  state;
  logic [idle_width-1:0]   idle;
  logic [vc_idx_width-1:0] ptr;
  logic [cred_width-1:0]   cred [num_vcs];
  logic                    cred_err;

  logic                    flit_valid;
  logic [vc_idx_width-1:0] flit_vc;
  logic                    flit_head;
  logic                    flit_tail;

  logic [num_vcs-1:0]      elig;
  logic [num_vcs-1:0]      gnt_raw;
  logic [num_vcs-1:0]      gnt;
  logic [vc_idx_width-1:0] gnt_idx;
  logic [vc_idx_width-1:0] ptr_nxt;
  logic                    any_gnt;
  logic                    any_elig;
  logic                    found;
  int                      j;

  always_comb begin
    for (int v = 0; v < num_vcs; v++) begin
      elig[v] = ch.req_ivc[v] & (cred[v] != '0);
    end
  end

  // Scan starts at the pointer and wraps, so the first hit wins.
  always_comb begin
    gnt_raw = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = 0;
    for (int i = 0; i < num_vcs; i++) begin
      j = int'(ptr) + i;
      if (j >= num_vcs) j = j - num_vcs;
      if (!found && elig[j]) begin
        gnt_raw[j] = 1'b1;
        gnt_idx    = vc_idx_width'(j);
        found      = 1'b1;
      end
    end
  end

  assign any_elig = |elig;
  assign gnt = (active && state == ACTIVE) ? gnt_raw : '0;
  assign any_gnt = |gnt;
  assign ptr_nxt =
    (gnt_idx == last_vc) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= reset_state;
      idle       <= '0;
      ptr        <= '0;
      flit_valid <= 1'b0;
      flit_vc    <= '0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
    end else if (active) begin
      if (any_gnt) begin
        ptr     <= ptr_nxt;
        flit_vc <= gnt_idx;
      end
      flit_valid <= any_gnt;
      flit_head  <= any_gnt & ch.req_head_ivc[gnt_idx];
      flit_tail  <= any_gnt & ch.req_tail_ivc[gnt_idx];
      if (enable_link_pm != 0) begin
        unique case (state)
          SLEEP: begin
            if (any_elig) begin
              state <= ACTIVE;
              idle  <= '0;
            end
          end
          ACTIVE: begin
            if (any_gnt) idle <= '0;
            else if (idle != idle_max) idle <= idle + 1'b1;
            if (idle == idle_max && !any_elig) state <= SLEEP;
          end
          default: state <= reset_state;
        endcase
      end
    end
  end

  // A credit on a full counter is dropped and flagged until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < num_vcs; v++) cred[v] <= cred_max;
      cred_err <= 1'b0;
    end else if (active) begin
      for (int v = 0; v < num_vcs; v++) begin
        unique case ({gnt[v], ch.credit_ivc[v]})
          2'b10: cred[v] <= cred[v] - 1'b1;
          2'b01: begin
            if (cred[v] == cred_max) cred_err <= 1'b1;
            else cred[v] <= cred[v] + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign ch.gnt_ivc         = gnt;
  assign ch.flit_valid_out  = flit_valid;
  assign ch.flit_vc_out     = flit_vc;
  assign ch.flit_head_out   = flit_head;
  assign ch.flit_tail_out   = flit_tail;
  assign ch.link_active_out = (state == ACTIVE);
  assign ch.credit_err_out  = cred_err;
endmodule

// File: tb/tb_rtr_channel_output_sched.sv
// Directed bench for rtr_channel_output_sched (4 VCs, depth 8,
// link PM on, idle timeout 4).
module tb_rtr_channel_output_sched;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic active = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n;

  always #5 clk = ~clk;

  rtr_channel_output_sched_if #(.num_vcs(4)) ch ();

  rtr_channel_output_sched #(
    .num_vcs(4),
    .buffer_size(8),
    .enable_link_pm(1),
    .idle_timeout(4)
  ) u_dut (
    .clk(clk),
    .reset(reset),
    .active(active),
    .ch(ch.master)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    active = 1'b1;
    ch.req_ivc = '0;
    ch.req_head_ivc = '0;
    ch.req_tail_ivc = '0;
    ch.credit_ivc = '0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    // round-robin wake and streaming
    do_reset();
    check("rst_link", ch.link_active_out, 0);
    check("rst_valid", ch.flit_valid_out, 0);
    check("rst_vc", ch.flit_vc_out, 0);
    check("rst_err", ch.credit_err_out, 0);
    check("rst_gnt", ch.gnt_ivc, 0);
    ch.req_head_ivc = 4'hF;
    ch.req_ivc = 4'hF;
    #1;
    check("sleep_gnt", ch.gnt_ivc, 0);
    step();
    check("wake_link", ch.link_active_out, 1);
    check("wake_valid", ch.flit_valid_out, 0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        step();
        check("rr_valid", ch.flit_valid_out, 1);
        check("rr_vc", ch.flit_vc_out, (k - 1) % 4);
      end
      check("rr_gnt", ch.gnt_ivc, 32'(1) << (k % 4));
    end
    step();
    check("rr_last_vc", ch.flit_vc_out, 1);
    check("rr_head", ch.flit_head_out, 1);
    check("rr_tail", ch.flit_tail_out, 0);
    active = 1'b0;
    #1;
    check("inact_gnt", ch.gnt_ivc, 0);
    step();
    check("inact_valid", ch.flit_valid_out, 1);
    check("inact_vc", ch.flit_vc_out, 1);
    active = 1'b1;
    #1;
    check("inact_ptr", ch.gnt_ivc, 4'b0100);

    // credit exhaustion on VC2
    do_reset();
    ch.req_tail_ivc = 4'b0100;
    ch.req_ivc = 4'b0100;
    #1;
    check("vc2_sleep", ch.gnt_ivc, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("vc2_gnt", ch.gnt_ivc, 4'b0100);
    end
    step();
    check("vc2_empty", ch.gnt_ivc, 0);
    check("vc2_tail", ch.flit_tail_out, 1);
    check("vc2_head", ch.flit_head_out, 0);
    check("vc2_vc", ch.flit_vc_out, 2);
    ch.credit_ivc = 4'b0100;
    #1;
    check("vc2_cred_cyc", ch.gnt_ivc, 0);
    step();
    ch.credit_ivc = '0;
    #1;
    check("vc2_ninth", ch.gnt_ivc, 4'b0100);
    step();
    check("vc2_spent", ch.gnt_ivc, 0);

    // grant and credit in the same cycle
    do_reset();
    ch.req_ivc = 4'b0010;
    step();
    for (int k = 0; k < 3; k++) begin
      check("same_pre", ch.gnt_ivc, 4'b0010);
      step();
    end
    ch.credit_ivc = 4'b0010;
    #1;
    check("same_gnt", ch.gnt_ivc, 4'b0010);
    step();
    ch.credit_ivc = '0;
    #1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (ch.gnt_ivc[1]) n++;
      step();
    end
    check("same_cred_left", n, 5);
    ch.req_ivc = '0;

    // credit overflow
    do_reset();
    ch.credit_ivc = 4'b0010;
    step();
    ch.credit_ivc = '0;
    #1;
    check("ovf_err", ch.credit_err_out, 1);
    step();
    step();
    check("ovf_sticky", ch.credit_err_out, 1);
    ch.req_ivc = 4'b0010;
    #1;
    n = 0;
    for (int k = 0; k < 14; k++) begin
      if (ch.gnt_ivc[1]) n++;
      step();
    end
    check("ovf_sat", n, 8);
    ch.req_ivc = '0;
    check("ovf_hold", ch.credit_err_out, 1);
    do_reset();
    check("ovf_clr", ch.credit_err_out, 0);

    // idle timeout to sleep
    do_reset();
    ch.req_ivc = 4'b0001;
    step();
    check("to_gnt", ch.gnt_ivc, 4'b0001);
    step();
    ch.req_ivc = '0;
    check("to_valid", ch.flit_valid_out, 1);
    check("to_link1", ch.link_active_out, 1);
    for (int k = 2; k <= 5; k++) begin
      step();
      if (k == 2) check("to_after", ch.flit_valid_out, 0);
      check("to_link", ch.link_active_out, 1);
    end
    step();
    check("to_sleep", ch.link_active_out, 0);

    // request arriving at the idle limit
    do_reset();
    ch.req_ivc = 4'b0001;
    step();
    step();
    ch.req_ivc = '0;
    for (int k = 2; k <= 5; k++) step();
    ch.req_ivc = 4'b0001;
    #1;
    check("lim_gnt", ch.gnt_ivc, 4'b0001);
    check("lim_link", ch.link_active_out, 1);
    step();
    check("lim_stay", ch.link_active_out, 1);
    check("lim_valid", ch.flit_valid_out, 1);
    ch.req_ivc = '0;

    // asynchronous reset mid-stream
    do_reset();
    ch.req_ivc = 4'hF;
    step();
    step();
    step();
    check("ar_pre", ch.flit_valid_out, 1);
    #3;
    reset = 1'b0;
    #1;
    check("ar_valid", ch.flit_valid_out, 0);
    check("ar_link", ch.link_active_out, 0);
    check("ar_vc", ch.flit_vc_out, 0);
    check("ar_gnt", ch.gnt_ivc, 0);
    step();
    step();
    reset = 1'b1;
    #1;
    check("ar_sleep", ch.gnt_ivc, 0);
    step();
    check("ar_vc0", ch.gnt_ivc, 4'b0001);
    step();
    check("ar_vc1", ch.gnt_ivc, 4'b0010);
    check("ar_flit", ch.flit_vc_out, 0);
    ch.req_ivc = '0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
